// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: N-channel, WIDTH-bit multiplexer with a registered valid/ready
// output. Direct mode follows sel; scan mode visits the channels enabled in
// ch_mask round-robin, holding each one for a programmable dwell time.
module mux_scan_nto1 #(
  parameter int unsigned N       = 16,
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned SEL_W   = $clog2(N),
  parameter int unsigned DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 scan_en,
  input  logic [N-1:0]         ch_mask,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [WIDTH-1:0]     out,
  output logic [SEL_W-1:0]     out_ch,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    ST_DIRECT    = 2'd0,
    ST_SCAN_WAIT = 2'd1,
    ST_SCAN_HOLD = 2'd2
  } state_t;

  // sel can only exceed N-1 when N is not a power of two
  localparam int unsigned SEL_SPAN = 1 << SEL_W;
  localparam bit          HAS_OOR  = SEL_SPAN > N;

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [DWELL_W-1:0] dwell_cnt;

  logic [WIDTH-1:0]   ch_data [N];
  logic               sel_oor_c;
  logic [WIDTH-1:0]   direct_data_c;
  logic [SEL_W-1:0]   first_ptr_c;
  logic [SEL_W-1:0]   next_ptr_c;
  logic [DWELL_W-1:0] dwell_lim_c;
  logic               expire_c;
  logic               mask_any_c;
  logic               ptr_on_c;
  logic               reg_free_c;
  logic               cap_c;
  logic [WIDTH-1:0]   cap_data_c;
  logic [SEL_W-1:0]   cap_ch_c;
  logic               cap_err_c;

  // Unpack the flat input bus into per-channel words
  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch_data[k] = in[k*WIDTH +: WIDTH];
  end

  // Out-of-range detection for direct-mode select
  if (HAS_OOR) begin : g_oor
    assign sel_oor_c = sel > SEL_W'(N - 1);
  end else begin : g_no_oor
    assign sel_oor_c = 1'b0;
  end

  assign direct_data_c = sel_oor_c ? '0 : ch_data[sel];
  assign mask_any_c    = |ch_mask;
  assign ptr_on_c      = ch_mask[ptr];
  assign reg_free_c    = !out_valid || out_ready;

  // A dwell of zero behaves like a dwell of one
  assign dwell_lim_c = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign expire_c    = dwell_cnt >= dwell_lim_c;

  // Lowest enabled channel, used as the scan starting point
  always_comb begin
    first_ptr_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (ch_mask[SEL_W'(N - 1 - k)]) first_ptr_c = SEL_W'(N - 1 - k);
    end
  end

  // Next enabled channel above ptr with wrap; the last hit is the nearest
  always_comb begin
    int unsigned idx;
    idx        = 0;
    next_ptr_c = ptr;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + N - i;
      if (idx >= N) idx = idx - N;
      if (ch_mask[SEL_W'(idx)]) next_ptr_c = SEL_W'(idx);
    end
  end

  // Capture decision and payload for the output register
  always_comb begin
    cap_c      = 1'b0;
    cap_data_c = direct_data_c;
    cap_ch_c   = sel;
    cap_err_c  = sel_oor_c;
    case (state)
      ST_DIRECT: begin
        cap_c = !scan_en && reg_free_c;
      end
      ST_SCAN_WAIT: begin
        cap_c      = scan_en && mask_any_c && expire_c && ptr_on_c && reg_free_c;
        cap_data_c = ch_data[ptr];
        cap_ch_c   = ptr;
        cap_err_c  = 1'b0;
      end
      ST_SCAN_HOLD: begin
        cap_c      = scan_en && ptr_on_c && reg_free_c;
        cap_data_c = ch_data[ptr];
        cap_ch_c   = ptr;
        cap_err_c  = 1'b0;
      end
      default: cap_c = 1'b0;
    endcase
  end

  // Mode FSM with scan pointer and dwell counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_DIRECT;
      ptr       <= '0;
      dwell_cnt <= '0;
    end else begin
      case (state)
        ST_DIRECT: begin
          if (scan_en) begin
            state     <= ST_SCAN_WAIT;
            ptr       <= first_ptr_c;
            dwell_cnt <= '0;
          end
        end
        ST_SCAN_WAIT: begin
          if (!scan_en) begin
            state <= ST_DIRECT;
          end else if (!mask_any_c) begin
            dwell_cnt <= '0;
          end else if (expire_c) begin
            if (!ptr_on_c || reg_free_c) begin
              ptr       <= next_ptr_c;
              dwell_cnt <= '0;
            end else begin
              state <= ST_SCAN_HOLD;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end
        ST_SCAN_HOLD: begin
          if (!scan_en) begin
            state <= ST_DIRECT;
          end else if (!mask_any_c) begin
            state     <= ST_SCAN_WAIT;
            dwell_cnt <= '0;
          end else if (!ptr_on_c || reg_free_c) begin
            state     <= ST_SCAN_WAIT;
            ptr       <= next_ptr_c;
            dwell_cnt <= '0;
          end
        end
        default: state <= ST_DIRECT;
      endcase
    end
  end

  // Output register with valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_ch    <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (cap_c) begin
      out       <= cap_data_c;
      out_ch    <= cap_ch_c;
      out_err   <= cap_err_c;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench for mux_scan_nto1: a 16x1 instance for direct/scan
// behaviour and a 12x4 instance for out-of-range select handling.
module tb_mux_scan_nto1;

  logic clk = 1'b0;
  logic rst_n;

  logic [15:0] in16;
  logic [3:0]  sel16;
  logic        scan_en16;
  logic [15:0] mask16;
  logic [7:0]  dwell16;
  logic [0:0]  out16;
  logic [3:0]  out_ch16;
  logic        err16;
  logic        valid16;
  logic        ready16;

  logic [47:0] in12;
  logic [3:0]  sel12;
  logic        scan_en12;
  logic [11:0] mask12;
  logic [7:0]  dwell12;
  logic [3:0]  out12;
  logic [3:0]  out_ch12;
  logic        err12;
  logic        valid12;
  logic        ready12;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_scan_nto1 #(.N(16), .WIDTH(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in(in16), .sel(sel16), .scan_en(scan_en16),
    .ch_mask(mask16), .dwell(dwell16), .out(out16), .out_ch(out_ch16),
    .out_err(err16), .out_valid(valid16), .out_ready(ready16)
  );

  mux_scan_nto1 #(.N(12), .WIDTH(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .in(in12), .sel(sel12), .scan_en(scan_en12),
    .ch_mask(mask12), .dwell(dwell12), .out(out12), .out_ch(out_ch12),
    .out_err(err12), .out_valid(valid12), .out_ready(ready12)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: k-th channel visited by a round-robin scan of mask, from the lowest
  function automatic int nth_enabled(input logic [15:0] mask, input int k);
    int q[$];
    for (int i = 0; i < 16; i++) if (mask[i]) q.push_back(i);
    if (q.size() == 0) return -1;
    return q[k % q.size()];
  endfunction

  // Reference: direct-mode word of the 12x4 instance
  function automatic logic [3:0] word12(input logic [47:0] v, input int s);
    if (s >= 12) return 4'h0;
    return v[s*4 +: 4];
  endfunction

  task automatic enter_scan16();
    scan_en16 = 1'b0;
    tick();
    scan_en16 = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if (out16 !== 1'b0 || out_ch16 !== 4'd0 || err16 !== 1'b0 || valid16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset16: out=%0d ch=%0d err=%0d valid=%0d, expected all 0",
               out16, out_ch16, err16, valid16);
    end
    n_checks++;
    if (out12 !== 4'd0 || out_ch12 !== 4'd0 || err12 !== 1'b0 || valid12 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset12: out=%0d ch=%0d err=%0d valid=%0d, expected all 0",
               out12, out_ch12, err12, valid12);
    end
  endtask

  task automatic test_direct_plan();
    int sels [5] = '{0, 5, 7, 1, 2};
    in16 = 16'hAA56; scan_en16 = 1'b0; ready16 = 1'b1;
    foreach (sels[i]) begin
      sel16 = 4'(sels[i]);
      tick();
      n_checks++;
      if (out16 !== in16[sels[i]] || out_ch16 !== 4'(sels[i]) || valid16 !== 1'b1 || err16 !== 1'b0) begin
        n_fail++;
        $display("FAIL direct16 sel=%0d: out=%0d ch=%0d valid=%0d err=%0d, expected out=%0d ch=%0d valid=1 err=0",
                 sels[i], out16, out_ch16, valid16, err16, in16[sels[i]], sels[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    in12 = {$urandom, $urandom}; scan_en12 = 1'b0; ready12 = 1'b1;
    sel12 = 4'd13;
    tick();
    n_checks++;
    if (out12 !== 4'd0 || err12 !== 1'b1 || out_ch12 !== 4'd13 || valid12 !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_sel13: out=%0d err=%0d ch=%0d valid=%0d, expected out=0 err=1 ch=13 valid=1",
               out12, err12, out_ch12, valid12);
    end
    sel12 = 4'd3;
    tick();
    n_checks++;
    if (out12 !== word12(in12, 3) || err12 !== 1'b0 || out_ch12 !== 4'd3) begin
      n_fail++;
      $display("FAIL oor_sel3: out=%0d err=%0d ch=%0d, expected out=%0d err=0 ch=3",
               out12, err12, out_ch12, word12(in12, 3));
    end
  endtask

  task automatic test_direct_backpressure();
    logic       m_valid = 1'b1;
    logic [3:0] m_out   = word12(in12, 3);
    logic [3:0] m_ch    = 4'd3;
    logic       m_err   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      ready12 = ($urandom_range(0, 2) != 0);
      sel12   = 4'($urandom_range(0, 15));
      in12    = {$urandom, $urandom};
      if (!m_valid || ready12) begin
        m_out = word12(in12, int'(sel12)); m_ch = sel12;
        m_err = (sel12 >= 4'd12); m_valid = 1'b1;
      end
      tick();
      n_checks++;
      if (out12 !== m_out || out_ch12 !== m_ch || err12 !== m_err || valid12 !== m_valid) begin
        n_fail++;
        $display("FAIL direct_bp c=%0d: out=%0d ch=%0d err=%0d valid=%0d, expected out=%0d ch=%0d err=%0d valid=%0d",
                 c, out12, out_ch12, err12, valid12, m_out, m_ch, m_err, m_valid);
      end
    end
    ready12 = 1'b1;
  endtask

  task automatic test_scan_basic();
    int dv [2] = '{2, 0};
    int acc_ch[$]; int acc_cyc[$]; logic acc_v[$];
    int de, ex;
    in16 = 16'hAA56; mask16 = 16'h0013; ready16 = 1'b1;
    foreach (dv[j]) begin
      dwell16 = 8'(dv[j]);
      de = (dv[j] == 0) ? 1 : dv[j];
      enter_scan16();
      acc_ch.delete(); acc_cyc.delete(); acc_v.delete();
      for (int c = 0; c < 24; c++) begin
        if (valid16 && ready16) begin
          acc_ch.push_back(int'(out_ch16)); acc_v.push_back(out16[0]); acc_cyc.push_back(c);
        end
        tick();
      end
      n_checks++;
      if (acc_ch.size() < 24 / de - 2) begin
        n_fail++;
        $display("FAIL scan_count dwell=%0d: got %0d samples, expected at least %0d",
                 dv[j], acc_ch.size(), 24 / de - 2);
      end
      foreach (acc_ch[k]) begin
        ex = nth_enabled(mask16, k);
        n_checks++;
        if (acc_ch[k] != ex || acc_v[k] !== in16[ex] || acc_cyc[k] != de * (k + 1)) begin
          n_fail++;
          $display("FAIL scan_seq dwell=%0d k=%0d: ch=%0d val=%0d cyc=%0d, expected ch=%0d val=%0d cyc=%0d",
                   dv[j], k, acc_ch[k], acc_v[k], acc_cyc[k], ex, in16[ex], de * (k + 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc_ch[$]; logic acc_v[$];
    int stall_left = 0;
    bit stalled = 0;
    int ex;
    in16 = 16'hAA56; mask16 = 16'h0013; dwell16 = 8'd2; ready16 = 1'b1;
    enter_scan16();
    for (int c = 0; c < 40; c++) begin
      if (!stalled && valid16 && out_ch16 == 4'd1) begin
        stall_left = 5; stalled = 1;
      end
      if (stall_left > 0) begin
        n_checks++;
        if (valid16 !== 1'b1 || out16 !== 1'b1 || out_ch16 !== 4'd1) begin
          n_fail++;
          $display("FAIL bp_hold c=%0d: valid=%0d out=%0d ch=%0d, expected valid=1 out=1 ch=1",
                   c, valid16, out16, out_ch16);
        end
        stall_left--;
        ready16 = 1'b0;
      end else begin
        ready16 = 1'b1;
      end
      if (valid16 && ready16) begin
        acc_ch.push_back(int'(out_ch16)); acc_v.push_back(out16[0]);
      end
      tick();
    end
    ready16 = 1'b1;
    n_checks++;
    if (!stalled || acc_ch.size() < 10) begin
      n_fail++;
      $display("FAIL bp_count: stalled=%0d samples=%0d, expected stalled=1 samples>=10",
               stalled, acc_ch.size());
    end
    foreach (acc_ch[k]) begin
      ex = nth_enabled(mask16, k);
      n_checks++;
      if (acc_ch[k] != ex || acc_v[k] !== in16[ex]) begin
        n_fail++;
        $display("FAIL bp_seq k=%0d: ch=%0d val=%0d, expected ch=%0d val=%0d",
                 k, acc_ch[k], acc_v[k], ex, in16[ex]);
      end
    end
  endtask

  task automatic test_random_scan();
    int acc_ch[$]; logic acc_v[$];
    logic prev_hold; logic prev_out; logic [3:0] prev_ch;
    int ex;
    for (int r = 0; r < 3; r++) begin
      in16    = 16'($urandom);
      mask16  = 16'($urandom);
      if (mask16 == 16'h0) mask16 = 16'h0001;
      dwell16 = 8'($urandom_range(0, 3));
      ready16 = 1'b1;
      enter_scan16();
      acc_ch.delete(); acc_v.delete();
      prev_hold = 1'b0; prev_out = 1'b0; prev_ch = 4'd0;
      for (int c = 0; c < 120; c++) begin
        if (prev_hold) begin
          n_checks++;
          if (valid16 !== 1'b1 || out16[0] !== prev_out || out_ch16 !== prev_ch) begin
            n_fail++;
            $display("FAIL rnd_stable r=%0d c=%0d: valid=%0d out=%0d ch=%0d, expected valid=1 out=%0d ch=%0d",
                     r, c, valid16, out16, out_ch16, prev_out, prev_ch);
          end
        end
        ready16 = ($urandom_range(0, 3) != 0);
        if (valid16 && ready16) begin
          acc_ch.push_back(int'(out_ch16)); acc_v.push_back(out16[0]);
        end
        prev_hold = valid16 && !ready16; prev_out = out16[0]; prev_ch = out_ch16;
        tick();
      end
      ready16 = 1'b1;
      n_checks++;
      if (acc_ch.size() < 5) begin
        n_fail++;
        $display("FAIL rnd_count r=%0d: samples=%0d, expected at least 5", r, acc_ch.size());
      end
      foreach (acc_ch[k]) begin
        ex = nth_enabled(mask16, k);
        n_checks++;
        if (acc_ch[k] != ex || acc_v[k] !== in16[ex]) begin
          n_fail++;
          $display("FAIL rnd_seq r=%0d mask=%h k=%0d: ch=%0d val=%0d, expected ch=%0d val=%0d",
                   r, mask16, k, acc_ch[k], acc_v[k], ex, in16[ex]);
        end
      end
    end
  endtask

  task automatic test_mask_zero();
    int acc_ch[$]; logic acc_v[$];
    in16 = 16'hAA56; mask16 = 16'h0000; dwell16 = 8'd2; ready16 = 1'b1;
    enter_scan16();
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (valid16 !== 1'b0) begin
        n_fail++;
        $display("FAIL mask0_valid c=%0d: valid=%0d, expected 0", c, valid16);
      end
      tick();
    end
    mask16 = 16'h8000;
    for (int c = 0; c < 40; c++) begin
      if (valid16 && ready16) begin
        acc_ch.push_back(int'(out_ch16)); acc_v.push_back(out16[0]);
      end
      tick();
    end
    n_checks++;
    if (acc_ch.size() < 10) begin
      n_fail++;
      $display("FAIL mask15_count: samples=%0d, expected at least 10", acc_ch.size());
    end
    foreach (acc_ch[k]) begin
      n_checks++;
      if (acc_ch[k] != 15 || acc_v[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL mask15_seq k=%0d: ch=%0d val=%0d, expected ch=15 val=1", k, acc_ch[k], acc_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc_ch[$]; logic acc_v[$];
    in16 = 16'hAA56; mask16 = 16'h0013; dwell16 = 8'd1; ready16 = 1'b1;
    enter_scan16();
    tick(); tick();
    ready16 = 1'b0;
    tick(); tick();
    n_checks++;
    if (valid16 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: valid=%0d, expected 1", valid16);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (out16 !== 1'b0 || out_ch16 !== 4'd0 || valid16 !== 1'b0 || err16 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: out=%0d ch=%0d valid=%0d err=%0d, expected all 0",
               out16, out_ch16, valid16, err16);
    end
    scan_en16 = 1'b0; mask16 = 16'h0014; ready16 = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    scan_en16 = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      if (valid16 && ready16) begin
        acc_ch.push_back(int'(out_ch16)); acc_v.push_back(out16[0]);
      end
      tick();
    end
    n_checks++;
    if (acc_ch.size() < 2 || acc_ch[0] != 2 || acc_v[0] !== in16[2] || acc_ch[1] != 4) begin
      n_fail++;
      $display("FAIL rstmid_restart: samples=%0d first_ch=%0d, expected >=2 samples starting ch=2 then ch=4",
               acc_ch.size(), (acc_ch.size() > 0) ? acc_ch[0] : -1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in16 = '0; sel16 = '0; scan_en16 = 1'b0; mask16 = '0; dwell16 = '0; ready16 = 1'b1;
    in12 = '0; sel12 = '0; scan_en12 = 1'b0; mask12 = '0; dwell12 = '0; ready12 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_direct_plan();
    test_out_of_range();
    test_direct_backpressure();
    test_scan_basic();
    test_backpressure();
    test_random_scan();
    test_mask_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
